// File: rtl/key_pkg.sv
// Shared types and helpers for the key press classifier.
// The debouncer derives its timing from the same FREQ.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    HOLD
  } state_t;

  function automatic int cycles_per_ms(input int freq_mhz);
    return freq_mhz * 1000;
  endfunction

endpackage

// File: rtl/key_press_classifier_if.sv
// Debounced key edges in, gesture pulses out.
// The DUT takes the slave side.
interface key_press_classifier_if;

  logic enable;
  logic key_negedge;
  logic key_posedge;
  logic short_press;
  logic double_click;
  logic long_press;
  logic repeat_pulse;
  logic busy;

  modport master (
    output enable,
    output key_negedge,
    output key_posedge,
    input  short_press,
    input  double_click,
    input  long_press,
    input  repeat_pulse,
    input  busy
  );

  modport slave (
    input  enable,
    input  key_negedge,
    input  key_posedge,
    output short_press,
    output double_click,
    output long_press,
    output repeat_pulse,
    output busy
  );

endinterface

// File: rtl/key_press_classifier_ms_timebase.sv
// Millisecond timebase: cycle prescaler feeding a
// saturating ms counter, both cleared by clr.
module ms_timebase
  import key_pkg::*;
#(
  parameter int FREQ = 40,
  parameter int MS_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  output logic            ms_tick,
  output logic [MS_W-1:0] ms_cnt
);

  localparam int CPM = cycles_per_ms(FREQ);
  localparam int PW  = $clog2(CPM);

  logic [PW-1:0] prescaler;

  assign ms_tick = (prescaler == PW'(CPM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      ms_cnt    <= '0;
    end else if (clr) begin
      prescaler <= '0;
      ms_cnt    <= '0;
    end else begin
      prescaler <= ms_tick ? '0 : prescaler + 1'b1;
      if (ms_tick && ms_cnt != '1)
        ms_cnt <= ms_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_press_classifier.sv
// Classifies debounced key gestures into short press,
// double click, long press and auto-repeat pulses.
module key_press_classifier
  import key_pkg::*;
#(
  parameter int FREQ      = 40,
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 300,
  parameter int REPEAT_MS = 200,
  parameter int MS_W      = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  key_press_classifier_if.slave kif
);

  localparam int MS_MAX = (1 << MS_W) - 1;

  state_t          state, nxt;
  logic            clr;
  logic            ms_tick_unused;
  logic [MS_W-1:0] ms_cnt;
  logic            sp_d, dc_d, lp_d, rp_d;

  ms_timebase #(
    .FREQ (FREQ),
    .MS_W (MS_W)
  ) u_tb (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .ms_tick (ms_tick_unused),
    .ms_cnt  (ms_cnt)
  );

  always_comb begin
    nxt  = state;
    clr  = 1'b0;
    sp_d = 1'b0;
    dc_d = 1'b0;
    lp_d = 1'b0;
    rp_d = 1'b0;
    if (!kif.enable) begin
      nxt = IDLE;
      clr = 1'b1;
    end else if (!(kif.key_negedge && kif.key_posedge)) begin
      // edges take priority over a coincident timeout
      unique case (state)
        IDLE: begin
          if (kif.key_negedge) nxt = PRESS1;
        end
        PRESS1: begin
          if (kif.key_posedge) begin
            nxt = WAIT2;
          end else if (ms_cnt == MS_W'(LONG_MS)) begin
            nxt  = HOLD;
            lp_d = 1'b1;
          end
        end
        WAIT2: begin
          if (kif.key_negedge) begin
            nxt  = PRESS2;
            dc_d = 1'b1;
          end else if (ms_cnt == MS_W'(DCLICK_MS)) begin
            nxt  = IDLE;
            sp_d = 1'b1;
          end
        end
        PRESS2: begin
          if (kif.key_posedge) nxt = IDLE;
        end
        HOLD: begin
          if (kif.key_posedge) begin
            nxt = IDLE;
          end else if (ms_cnt == MS_W'(REPEAT_MS)) begin
            rp_d = 1'b1;
            clr  = 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
    end
    if (nxt != state) clr = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      kif.short_press  <= 1'b0;
      kif.double_click <= 1'b0;
      kif.long_press   <= 1'b0;
      kif.repeat_pulse <= 1'b0;
    end else begin
      state            <= nxt;
      kif.short_press  <= sp_d;
      kif.double_click <= dc_d;
      kif.long_press   <= lp_d;
      kif.repeat_pulse <= rp_d;
    end
  end

  assign kif.busy = (state != IDLE);

  always @(posedge clk) begin
    lim_ok: assert (LONG_MS > 0 && LONG_MS < MS_MAX &&
                    DCLICK_MS > 0 && DCLICK_MS < MS_MAX &&
                    REPEAT_MS > 0 && REPEAT_MS < MS_MAX)
      else $error("key_press_classifier: ms limit out of range");
  end

endmodule

// File: doc/key_press_classifier.md
Name: key_press_classifier

Overview:
- Sits directly downstream of the button debouncer.
- Consumes the debouncer's registered edge pulses and classifies each user gesture on the key as one of: short press, double click, long press, or auto-repeat while held.
- The key is idle-high: a press is the debounced negedge and a release is the debounced posedge.
- Outputs are single-cycle pulses for the control/UI logic.

Parameters:
- FREQ, 40, module clock in MHz.
- LONG_MS, 1000, hold time in ms that qualifies a long press.
- DCLICK_MS, 300, maximum release-to-second-press gap in ms for a double click.
- REPEAT_MS, 200, auto-repeat period in ms while held after a long press.
- MS_W, 16, width of the ms counter.

Ports:
- clk  in  1  module clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  classifier enable; low forces IDLE.
- key_negedge  in  1  one-cycle press pulse from the debouncer.
- key_posedge  in  1  one-cycle release pulse from the debouncer.
- short_press  out  1  one-cycle pulse: single short press.
- double_click  out  1  one-cycle pulse: second press inside the DCLICK_MS window.
- long_press  out  1  one-cycle pulse: key held LONG_MS.
- repeat_pulse  out  1  one-cycle pulse every REPEAT_MS while held after long_press.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, prescaler=0, ms_cnt=0, all outputs 0.
- ms timebase:
  - prescaler counts 0..FREQ*1000-1; ms_tick=1 on the terminal count, then wraps to 0.
  - ms_cnt increments on ms_tick and saturates at all-ones.
  - On every state transition, prescaler and ms_cnt are cleared in the same edge as the state update.
  - Timeout for limit L fires when ms_cnt==L, i.e. L*FREQ*1000 cycles after state entry.
- State IDLE:
  - key_negedge -> PRESS1.
  - key_posedge is ignored.
- State PRESS1:
  - key_posedge -> WAIT2.
  - ms_cnt==LONG_MS -> HOLD, pulse long_press.
- State WAIT2:
  - key_negedge -> PRESS2, pulse double_click.
  - ms_cnt==DCLICK_MS -> IDLE, pulse short_press.
- State PRESS2:
  - key_posedge -> IDLE.
  - No timeout; long press is not reported for the second press.
- State HOLD:
  - ms_cnt==REPEAT_MS -> pulse repeat_pulse, then clear the timebase and stay in HOLD.
  - key_posedge -> IDLE, no pulse.
- Output latency:
  - All output pulses are registered.
  - A pulse is high for exactly one cycle, in the cycle after the triggering edge or timeout cycle.
  - At most one of the four pulse outputs is high in any cycle.
- Simultaneous events:
  - key_negedge and key_posedge both high in one cycle is illegal upstream; the FSM holds state and the timebase keeps running.
  - An edge and a timeout in the same cycle: the edge wins. Example: key_posedge in PRESS1 at ms_cnt==LONG_MS -> WAIT2, no long_press.
- Short-press latency: short_press reports only after the DCLICK_MS window closes. This latency is intentional.
- enable=0:
  - Next edge forces IDLE, clears the timebase, and suppresses all pulses.
  - An in-progress gesture is discarded.
  - Re-enable with the key already held: no press is reported until the next key_negedge.
- Reset mid-gesture: state and outputs return to reset values immediately; no pulse is emitted on reset deassertion.
- Widths:
  - prescaler width is clog2(FREQ*1000).
  - LONG_MS, DCLICK_MS and REPEAT_MS must be < 2**MS_W - 1; this is checked by a simulation assertion.
  - Limits of 0 are illegal.

Decomposition:
- Shared package key_pkg holds:
  - the state enum (IDLE, PRESS1, WAIT2, PRESS2, HOLD);
  - a localparam function for the cycles-per-ms count from FREQ.
- The debouncer and this block share FREQ from the same top-level parameter.
- One sub-module, ms_timebase: prescaler plus saturating ms_cnt with a synchronous clr input and outputs ms_tick and ms_cnt.
- The FSM and output pulse registers live in key_press_classifier.

Test Plan:
All scenarios use FREQ=1 (1000 cycles/ms), LONG_MS=10, DCLICK_MS=3, REPEAT_MS=2, enable=1.
1. Single tap: press at t0, release at t0+2 ms -> short_press one cycle, 3 ms + 1 cycle after the release; no other pulses; busy returns to 0.
2. Double click: press, release at 1 ms, press again 2 ms after the release -> double_click one cycle after the second press; release -> IDLE; no short_press.
3. Long hold: press held 15 ms:
   - long_press at 10 ms + 1 cycle;
   - repeat_pulse at 12 ms and 14 ms (+1 cycle);
   - release at 15 ms -> IDLE with no further pulses.
4. Boundary: release exactly at the cycle ms_cnt reaches LONG_MS -> WAIT2, no long_press; short_press 3 ms later.
5. Gap boundary: second press 1 cycle after DCLICK_MS expiry -> short_press for the first tap, then a new PRESS1 gesture, no double_click.
6. Abort: rst_n low for 1 cycle during HOLD (or enable low) -> all outputs 0 and busy 0 immediately; the next release is ignored; the next press starts a clean gesture.
